alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with latched operands, an iterative shift-add
// multiplier, registered result/flags and 7-segment hex display drive.
// Ports:
//   CLOCK_50  clock, rising edge
//   RESET_N   asynchronous active-low reset
//   SW1, SW2  operands A and B (WIDTH bits)
//   KEY       3-bit opcode
//   START     level request, sampled only while idle
//   BUSY      high whenever an operation is in flight
//   DONE      one-cycle pulse while the new result is first visible
//   out       registered result
//   FLAGS     registered {Z,N,C,V}
//   HEX       active-low segments, digit k at [7k+6:7k], bit 6 = a
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int DIGITS = WIDTH / 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [WIDTH-1:0]      SW1,
    input  logic [WIDTH-1:0]      SW2,
    input  logic [2:0]            KEY,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [WIDTH-1:0]      out,
    output logic [3:0]            FLAGS,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [3:0]         flags_q, flags_d;

    // Single-cycle ALU on the latched operands.
    logic [WIDTH:0]   add_w, sub_ab, sub_ba;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    always_comb begin
        add_w  = {1'b0, a_q} + {1'b0, b_q};
        sub_ab = {1'b0, a_q} - {1'b0, b_q};
        sub_ba = {1'b0, b_q} - {1'b0, a_q};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op_q)
            3'b000: alu_res = '0;
            3'b001: begin
                alu_res = sub_ba[WIDTH-1:0];
                alu_c   = sub_ba[WIDTH];
                alu_v   = (b_q[WIDTH-1] != a_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != b_q[WIDTH-1]);
            end
            3'b010: begin
                alu_res = sub_ab[WIDTH-1:0];
                alu_c   = sub_ab[WIDTH];
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b011: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b100: alu_res = a_q ^ b_q;
            3'b101: alu_res = a_q | b_q;
            3'b110: alu_res = a_q & b_q;
            3'b111: alu_res = '0;
        endcase
    end

    // One shift-add step: prod holds {partial, remaining multiplier bits};
    // add A into the upper half when the next multiplier bit is set,
    // then shift the whole thing right, keeping the carry.
    logic [WIDTH:0]     psum;
    logic [2*WIDTH-1:0] prod_step;

    always_comb begin
        psum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
               (prod_q[0] ? {1'b0, a_q} : '0);
        prod_step = {psum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        out_d   = out_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d     = SW1;
                    b_d     = SW2;
                    op_d    = KEY;
                    cnt_d   = '0;
                    prod_d  = {{WIDTH{1'b0}}, SW2};
                    state_d = (KEY == 3'b111) ? MUL : EXEC;
                end
            end
            EXEC: begin
                out_d   = alu_res;
                flags_d = {alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v};
                state_d = FIN;
            end
            MUL: begin
                // WIDTH iteration cycles, then one cycle to publish.
                if (cnt_q != CW'(WIDTH)) begin
                    prod_d = prod_step;
                    cnt_d  = cnt_q + CW'(1);
                end else begin
                    out_d   = prod_q[WIDTH-1:0];
                    flags_d = {prod_q[WIDTH-1:0] == '0,
                               prod_q[WIDTH-1],
                               |prod_q[2*WIDTH-1:WIDTH],
                               1'b0};
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign BUSY  = (state_q != IDLE);
    assign DONE  = (state_q == FIN);
    assign out   = out_q;
    assign FLAGS = flags_q;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        assign HEX[7*k +: 7] = seg7(out_q[4*k +: 4]);
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed self-checking bench for alu_seq
// (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic [7:0]  SW1, SW2;
    logic [2:0]  KEY;
    logic        START;
    logic        BUSY, DONE;
    logic [7:0]  dout;
    logic [3:0]  flags;
    logic [13:0] hex;

    int checks;
    int failures;

    logic [6:0] seg_tbl [16];

    alu_seq #(.WIDTH(8)) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .SW1     (SW1),
        .SW2     (SW2),
        .KEY     (KEY),
        .START   (START),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .out     (dout),
        .FLAGS   (flags),
        .HEX     (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic void model(input int a, input int b, input int op,
                                  output logic [7:0] r,
                                  output logic [3:0] f);
        int res;
        int t;
        logic c;
        logic v;
        c = 1'b0;
        v = 1'b0;
        res = 0;
        case (op)
            1: begin
                res = b - a;
                c = (b < a);
                t = sx(b) - sx(a);
                v = (t > 127) || (t < -128);
            end
            2: begin
                res = a - b;
                c = (a < b);
                t = sx(a) - sx(b);
                v = (t > 127) || (t < -128);
            end
            3: begin
                res = a + b;
                c = (res > 255);
                t = sx(a) + sx(b);
                v = (t > 127) || (t < -128);
            end
            4: res = a ^ b;
            5: res = a | b;
            6: res = a & b;
            7: begin
                res = a * b;
                c = (res > 255);
            end
            default: res = 0;
        endcase
        r = 8'(res);
        f = {r == 8'h00, r[7], c, v};
    endfunction

    function automatic logic [13:0] exp_hex(input logic [7:0] v);
        return {seg_tbl[v[7:4]], seg_tbl[v[3:0]]};
    endfunction

    // Drive one request from an idle negedge and follow it to idle again.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op,
                         output logic [7:0] o, output logic [3:0] f,
                         output logic [13:0] h, output int lat,
                         output int busy, output int dones);
        int n;
        bit got;
        SW1 = a;
        SW2 = b;
        KEY = op;
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        n = 1;
        busy = 0;
        dones = 0;
        lat = 0;
        got = 0;
        o = '0;
        f = '0;
        h = '0;
        while (BUSY === 1'b1 && n < 40) begin
            busy++;
            if (DONE === 1'b1) begin
                dones++;
                if (!got) begin
                    got = 1;
                    lat = n;
                    o = dout;
                    f = flags;
                    h = hex;
                end
            end
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL timeout op=%0d busy never dropped", op);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        START = 1'b0;
        SW1 = 8'hA5;
        SW2 = 8'h5A;
        KEY = 3'b011;
        repeat (2) @(negedge clk);
        checks++;
        if (dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_out got=%h exp=00", dout);
        end
        checks++;
        if (flags !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", flags);
        end
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy_done got=%b%b exp=00", BUSY, DONE);
        end
        checks++;
        if (hex !== 14'b0000001_0000001) begin
            failures++;
            $display("FAIL reset_hex got=%b exp=%b", hex,
                     14'b0000001_0000001);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_op(input string name, input logic [7:0] a,
                            input logic [7:0] b, input logic [2:0] op);
        logic [7:0]  o, eo;
        logic [3:0]  f, ef;
        logic [13:0] h;
        int lat, busy, dones, elat;
        model(int'(a), int'(b), int'(op), eo, ef);
        elat = (op == 3'b111) ? 10 : 2;
        issue(a, b, op, o, f, h, lat, busy, dones);
        checks++;
        if (o !== eo) begin
            failures++;
            $display("FAIL %s out a=%h b=%h op=%0d got=%h exp=%h",
                     name, a, b, op, o, eo);
        end
        checks++;
        if (f !== ef) begin
            failures++;
            $display("FAIL %s flags a=%h b=%h op=%0d got=%b exp=%b",
                     name, a, b, op, f, ef);
        end
        checks++;
        if (lat != elat || busy != elat || dones != 1) begin
            failures++;
            $display("FAIL %s timing op=%0d lat=%0d busy=%0d dones=%0d exp=%0d/%0d/1",
                     name, op, lat, busy, dones, elat, elat);
        end
        checks++;
        if (h !== exp_hex(eo)) begin
            failures++;
            $display("FAIL %s hex got=%b exp=%b", name, h, exp_hex(eo));
        end
    endtask

    task automatic test_directed;
        check_op("add_c8_64", 8'hC8, 8'h64, 3'b011);
        checks++;
        if (hex !== {7'b0010010, 7'b0110001} || flags !== 4'b0010) begin
            failures++;
            $display("FAIL add_c8_64_hold hex=%b flags=%b exp=%b/0010",
                     hex, flags, {7'b0010010, 7'b0110001});
        end
        check_op("sub_05_07", 8'h05, 8'h07, 3'b010);
        check_op("add_7f_01", 8'h7F, 8'h01, 3'b011);
        check_op("mul_0f_11", 8'h0F, 8'h11, 3'b111);
        check_op("mul_10_10", 8'h10, 8'h10, 3'b111);
        check_op("rsub_01_00", 8'h01, 8'h00, 3'b001);
        check_op("zero_op", 8'hFF, 8'hFF, 3'b000);
    endtask

    task automatic test_random;
        logic [7:0] a, b;
        logic [2:0] op;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            check_op("random", a, b, op);
        end
    endtask

    task automatic test_mul_ignore;
        int n;
        int dones;
        logic [7:0] o;
        logic [3:0] f;
        SW1 = 8'h0F;
        SW2 = 8'h11;
        KEY = 3'b111;
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        n = 1;
        dones = 0;
        o = '0;
        f = '0;
        while (BUSY === 1'b1 && n < 40) begin
            SW1 = 8'($urandom);
            SW2 = 8'($urandom);
            KEY = 3'($urandom_range(0, 6));
            START = (n == 3 || n == 9);
            if (DONE === 1'b1) begin
                dones++;
                o = dout;
                f = flags;
            end
            @(negedge clk);
            n++;
        end
        START = 1'b0;
        checks++;
        if (o !== 8'hFF || f !== 4'b0100) begin
            failures++;
            $display("FAIL mul_ignore result got=%h/%b exp=ff/0100", o, f);
        end
        checks++;
        if (dones != 1 || n != 11) begin
            failures++;
            $display("FAIL mul_ignore dones=%0d busy_end=%0d exp=1/11",
                     dones, n);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (BUSY !== 1'b0 || dout !== 8'hFF) begin
            failures++;
            $display("FAIL mul_ignore_after busy=%b out=%h exp=0/ff",
                     BUSY, dout);
        end
    endtask

    task automatic test_reset_mid_mul;
        int dones;
        int busys;
        check_op("pre_reset", 8'hC8, 8'h64, 3'b011);
        SW1 = 8'h0F;
        SW2 = 8'h11;
        KEY = 3'b111;
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 8'h00 || flags !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_out got=%h/%b exp=00/0000", dout, flags);
        end
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL midreset_busy got=%b%b exp=00", BUSY, DONE);
        end
        checks++;
        if (hex !== 14'b0000001_0000001) begin
            failures++;
            $display("FAIL midreset_hex got=%b exp=%b", hex,
                     14'b0000001_0000001);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        busys = 0;
        repeat (14) begin
            @(negedge clk);
            if (DONE === 1'b1) dones++;
            if (BUSY === 1'b1) busys++;
        end
        checks++;
        if (dones != 0 || busys != 0 || dout !== 8'h00) begin
            failures++;
            $display("FAIL midreset_after dones=%0d busy=%0d out=%h exp=0/0/00",
                     dones, busys, dout);
        end
        check_op("post_reset", 8'h12, 8'h34, 3'b101);
    endtask

    task automatic test_back_to_back;
        logic [7:0] er [$];
        logic [3:0] ef [$];
        logic [7:0] a, b, r;
        logic [2:0] op;
        logic [3:0] f;
        int issued, got, cyc, last;
        issued = 0;
        got = 0;
        cyc = 0;
        last = -1;
        while (got < 4 && cyc < 60) begin
            if (BUSY === 1'b0 && issued < 4) begin
                a = 8'($urandom);
                b = 8'($urandom);
                op = 3'($urandom_range(0, 6));
                SW1 = a;
                SW2 = b;
                KEY = op;
                START = 1'b1;
                model(int'(a), int'(b), int'(op), r, f);
                er.push_back(r);
                ef.push_back(f);
                issued++;
            end
            if (DONE === 1'b1) begin
                checks++;
                if (er.size() == 0) begin
                    failures++;
                    $display("FAIL b2b unexpected DONE at cycle %0d", cyc);
                end else begin
                    r = er.pop_front();
                    f = ef.pop_front();
                    if (dout !== r || flags !== f) begin
                        failures++;
                        $display("FAIL b2b result got=%h/%b exp=%h/%b",
                                 dout, flags, r, f);
                    end
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 3) begin
                        failures++;
                        $display("FAIL b2b gap got=%0d exp=3", cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        START = 1'b0;
        checks++;
        if (got != 4) begin
            failures++;
            $display("FAIL b2b completions got=%0d exp=4", got);
        end
        @(negedge clk);
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL b2b stop busy=%b exp=0", BUSY);
        end
    endtask

    task automatic test_hex_sweep;
        logic [7:0]  o;
        logic [3:0]  f;
        logic [13:0] h;
        int lat, busy, dones;
        int bad;
        bad = 0;
        for (int v = 0; v < 256; v++) begin
            issue(8'(v), 8'h00, 3'b011, o, f, h, lat, busy, dones);
            checks++;
            if (o !== 8'(v) || h !== exp_hex(8'(v))) begin
                failures++;
                bad++;
                if (bad < 8)
                    $display("FAIL hex_sweep v=%h out=%h hex=%b exp=%b",
                             v[7:0], o, h, exp_hex(8'(v)));
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        seg_tbl[0]  = 7'b0000001;
        seg_tbl[1]  = 7'b1001111;
        seg_tbl[2]  = 7'b0010010;
        seg_tbl[3]  = 7'b0000110;
        seg_tbl[4]  = 7'b1001100;
        seg_tbl[5]  = 7'b0100100;
        seg_tbl[6]  = 7'b0100000;
        seg_tbl[7]  = 7'b0001111;
        seg_tbl[8]  = 7'b0000000;
        seg_tbl[9]  = 7'b0000100;
        seg_tbl[10] = 7'b0001000;
        seg_tbl[11] = 7'b1100000;
        seg_tbl[12] = 7'b0110001;
        seg_tbl[13] = 7'b1000010;
        seg_tbl[14] = 7'b0110000;
        seg_tbl[15] = 7'b0111000;
        test_reset;
        test_directed;
        test_random;
        test_mul_ignore;
        test_reset_mid_mul;
        test_back_to_back;
        test_hex_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
